// File: rtl/sram_mac_engine.sv
// Multi-lane weight-stationary SRAM multiplier / MAC engine with ready/valid streaming.
// Weights load in a LOAD phase, then operands stream against them in MUL or MAC mode.
package sram_mac_pkg;
    typedef struct packed {
        logic we;
        logic accept;
        logic first;
        logic last;
        logic mac;
        logic sgn;
        logic clr;
    } lane_ctrl_t;
endpackage

module sram_mac_lane
    import sram_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  lane_ctrl_t            ctrl,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0]  result
);
    logic [DATA_WIDTH-1:0]          mem [DEPTH];
    logic [DATA_WIDTH-1:0]          w;
    logic signed [2*DATA_WIDTH-1:0] sprod;
    logic [2*DATA_WIDTH-1:0]        uprod;
    logic [ACC_WIDTH-1:0]           prod, acc, sum;

    // Weight storage has no reset; contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (rst_n && ctrl.we) mem[wr_addr] <= wdata;
    end

    assign w     = mem[rd_addr];
    assign sprod = (2*DATA_WIDTH)'($signed(din)) * (2*DATA_WIDTH)'($signed(w));
    assign uprod = (2*DATA_WIDTH)'(din) * (2*DATA_WIDTH)'(w);
    assign prod  = ctrl.sgn ? ACC_WIDTH'(sprod) : ACC_WIDTH'(uprod);
    assign sum   = ctrl.first ? prod : acc + prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
        end else if (ctrl.clr) begin
            acc <= '0;
        end else if (ctrl.accept) begin
            if (ctrl.mac) begin
                acc <= sum;
                if (ctrl.last) result <= sum;
            end else begin
                result <= prod;
            end
        end
    end
endmodule

module sram_mac_engine
    import sram_mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        init_enable,
    input  logic [LANES*DATA_WIDTH-1:0] init_data,
    input  logic                        mode,
    input  logic                        signed_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*ACC_WIDTH-1:0]  data_out,
    output logic                        init_done,
    output logic [ADDR_WIDTH-1:0]       addr
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                               state, state_nxt;
    logic [ADDR_WIDTH-1:0]                addr_nxt, wr_addr;
    logic                                 done_nxt, ov_nxt, accept, first, last;
    logic                                 mode_q, sgn_q;
    lane_ctrl_t                           ctrl;
    logic [LANES-1:0][DATA_WIDTH-1:0]     wdata;
    logic [LANES-1:0][ACC_WIDTH-1:0]      lane_out;

    assign wdata    = init_data;
    assign data_out = lane_out;
    assign in_ready = ce && init_done && (!out_valid || out_ready);
    // A simultaneous reload request beats the operand.
    assign accept   = in_ready && in_valid && !init_enable;
    assign first    = (addr == '0);
    assign last     = (addr == ADDR_WIDTH'(DEPTH-1));
    assign wr_addr  = (state == RUN) ? '0 : addr;

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        done_nxt    = init_done;
        ov_nxt      = out_valid;
        ctrl        = '0;
        ctrl.accept = accept;
        ctrl.first  = first;
        ctrl.last   = last;
        ctrl.mac    = first ? mode : mode_q;
        ctrl.sgn    = first ? signed_en : sgn_q;
        if (ce) begin
            case (state)
                IDLE: if (init_enable) begin
                    ctrl.we   = 1'b1;
                    addr_nxt  = addr + 1'b1;
                    state_nxt = LOAD;
                end
                LOAD: if (init_enable) begin
                    ctrl.we  = 1'b1;
                    addr_nxt = addr + 1'b1;
                    if (last) begin
                        addr_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = RUN;
                    end
                end
                RUN: if (init_enable) begin
                    ctrl.we   = 1'b1;
                    ctrl.clr  = 1'b1;
                    addr_nxt  = ADDR_WIDTH'(1);
                    done_nxt  = 1'b0;
                    ov_nxt    = 1'b0;
                    state_nxt = LOAD;
                end else begin
                    if (out_valid && out_ready) ov_nxt = 1'b0;
                    if (accept) begin
                        addr_nxt = addr + 1'b1;
                        if (!ctrl.mac || last) ov_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            init_done <= 1'b0;
            out_valid <= 1'b0;
            mode_q    <= 1'b0;
            sgn_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            init_done <= done_nxt;
            out_valid <= ov_nxt;
            if (accept && first) begin
                mode_q <= mode;
                sgn_q  <= signed_en;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sram_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ctrl    (ctrl),
            .wr_addr (wr_addr),
            .rd_addr (addr),
            .wdata   (wdata[k]),
            .din     (data_in),
            .result  (lane_out[k])
        );
    end
endmodule

// File: tb/tb_sram_mac_engine.sv
// Directed bench for sram_mac_engine: vector table for arithmetic, hand sequences for flow control.
module tb_sram_mac_engine;
    localparam int DW = 16, DEPTH = 32, AW = 5, LANES = 4, ACC = 37, OW = LANES*ACC;

    logic clk = 1'b0;
    logic rst_n, ce, init_enable, mode, signed_en, in_valid, in_ready;
    logic out_valid, out_ready, init_done;
    logic [LANES*DW-1:0] init_data;
    logic [DW-1:0]       data_in;
    logic [OW-1:0]       data_out;
    logic [AW-1:0]       addr;
    int checks = 0, errors = 0, pulses;

    always #5 clk = ~clk;

    sram_mac_engine dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .init_enable(init_enable),
        .init_data(init_data), .mode(mode), .signed_en(signed_en),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .init_done(init_done), .addr(addr)
    );

    typedef struct {
        logic           sgn;
        logic [DW-1:0]  din;
        logic [DW-1:0]  w;
        logic [ACC-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] lanes_eq(input logic [ACC-1:0] v);
        logic [OW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*ACC +: ACC] = v;
        return r;
    endfunction

    // Weight ramp w[k][a] = a+k+1 times operand 2.
    function automatic logic [OW-1:0] mulvec(input int i);
        logic [OW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*ACC +: ACC] = ACC'(2*((i % DEPTH) + k + 1));
        return r;
    endfunction

    function automatic logic [OW-1:0] macvec();
        logic [OW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*ACC +: ACC] = ACC'(528 + 32*k);
        return r;
    endfunction

    task automatic load(input bit rmp, input logic [DW-1:0] c);
        init_enable = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            for (int k = 0; k < LANES; k++)
                init_data[k*DW +: DW] = rmp ? DW'(a + k + 1) : c;
            tick;
            if (a == 0) begin
                chk("load_first_done", OW'(init_done), OW'(0));
                chk("load_first_ov", OW'(out_valid), OW'(0));
                chk("load_first_addr", OW'(addr), OW'(1));
            end
        end
        init_enable = 1'b0;
        in_valid    = 1'b0;
        chk("load_done", OW'(init_done), OW'(1));
        chk("load_addr", OW'(addr), OW'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 16'hFFFF, 16'hFFFF, 37'd1};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 37'h00FFFE0001};
        vecs[2] = '{1'b1, 16'h8000, 16'h8000, 37'h0040000000};
        vecs[3] = '{1'b1, 16'h7FFF, 16'h8000, 37'h1FC0008000};
        vecs[4] = '{1'b0, 16'h0003, 16'hFFFF, 37'd196605};
        vecs[5] = '{1'b1, 16'h0003, 16'hFFFF, 37'h1FFFFFFFFD};

        // reset with random inputs
        rst_n = 1'b0; ce = 1'($urandom); init_enable = 1'($urandom); mode = 1'($urandom);
        signed_en = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
        data_in = DW'($urandom); init_data = {$urandom, $urandom};
        tick; tick;
        chk("rst_in_ready", OW'(in_ready), OW'(0));
        chk("rst_out_valid", OW'(out_valid), OW'(0));
        chk("rst_data_out", data_out, OW'(0));
        chk("rst_init_done", OW'(init_done), OW'(0));
        chk("rst_addr", OW'(addr), OW'(0));

        rst_n = 1'b1; ce = 1'b1; init_enable = 1'b0; mode = 1'b0; signed_en = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
        tick;
        chk("idle_addr", OW'(addr), OW'(0));

        // MUL unsigned stream, 33 operands with wrap
        load(1'b1, '0);
        data_in = 16'd2; in_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            tick;
            chk($sformatf("mul_ov_%0d", i), OW'(out_valid), OW'(1));
            chk($sformatf("mul_data_%0d", i), data_out, mulvec(i));
            chk($sformatf("mul_done_%0d", i), OW'(init_done), OW'(1));
        end
        in_valid = 1'b0;
        tick;
        chk("mul_ov_clear", OW'(out_valid), OW'(0));

        // MAC full pass
        load(1'b1, '0);
        mode = 1'b1; data_in = 16'd1; in_valid = 1'b1; pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick;
            if (out_valid) pulses++;
        end
        chk("mac_sum", data_out, macvec());
        chk("mac_addr", OW'(addr), OW'(0));
        in_valid = 1'b0;
        tick;
        if (out_valid) pulses++;
        chk("mac_pulses", OW'(pulses), OW'(1));

        // backpressure during MUL
        mode = 1'b0; data_in = 16'd2; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("bp_pre_%0d", i), data_out, mulvec(i));
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_in_ready_%0d", c), OW'(in_ready), OW'(0));
            tick;
            chk($sformatf("bp_ov_%0d", c), OW'(out_valid), OW'(1));
            chk($sformatf("bp_hold_%0d", c), data_out, mulvec(2));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", OW'(in_ready), OW'(1));
        for (int i = 3; i < 7; i++) begin
            tick;
            chk($sformatf("bp_post_%0d", i), data_out, mulvec(i));
        end
        in_valid = 1'b0;

        // reload at addr 10 of a MAC pass, operand still offered
        load(1'b1, '0);
        mode = 1'b1; data_in = 16'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("reload_addr10", OW'(addr), OW'(10));
        load(1'b0, 16'd5);
        in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick;
        in_valid = 1'b0;
        chk("reload_ov", OW'(out_valid), OW'(1));
        chk("reload_sum", data_out, lanes_eq(37'd160));

        // ce=0 freezes everything
        ce = 1'b0; mode = 1'b0; in_valid = 1'b1;
        #1;
        chk("ce_in_ready", OW'(in_ready), OW'(0));
        tick; tick;
        chk("ce_ov_hold", OW'(out_valid), OW'(1));
        chk("ce_data_hold", data_out, lanes_eq(37'd160));
        chk("ce_addr_hold", OW'(addr), OW'(0));
        ce = 1'b1; in_valid = 1'b0;
        tick;

        // reset mid-LOAD
        init_enable = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        rst_n = 1'b0;
        tick;
        chk("rstload_done", OW'(init_done), OW'(0));
        chk("rstload_addr", OW'(addr), OW'(0));
        chk("rstload_ov", OW'(out_valid), OW'(0));
        chk("rstload_data", data_out, OW'(0));
        rst_n = 1'b1; init_enable = 1'b0;
        tick;
        chk("rstload_idle_addr", OW'(addr), OW'(0));
        chk("rstload_idle_done", OW'(init_done), OW'(0));
        chk("rstload_in_ready", OW'(in_ready), OW'(0));

        // signed / unsigned arithmetic table
        for (int v = 0; v < 6; v++) begin
            load(1'b0, vecs[v].w);
            mode = 1'b0; signed_en = vecs[v].sgn; data_in = vecs[v].din; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            chk($sformatf("vec_%0d_ov", v), OW'(out_valid), OW'(1));
            chk($sformatf("vec_%0d_data", v), data_out, lanes_eq(vecs[v].exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
